// File: rtl/iir_mac_sequencer.sv
// iir_mac_sequencer: Q16.16 biquad MAC sequencer over one shared external multiplier.
// Define IIR_SAT_EN for per-step saturating accumulation (default: wrap modulo 2^32).
module iir_mac_sequencer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        coef_we_i,
  input  logic [2:0]  coef_addr_i,
  input  logic [31:0] coef_data_i,
  input  logic        x_valid_i,
  input  logic [31:0] x_i,
  output logic        x_ready_o,
  output logic        y_valid_o,
  output logic [31:0] y_o,
  output logic        busy_o,
  output logic [31:0] mult_a_o,
  output logic [31:0] mult_b_o,
  input  logic [31:0] mult_p_i
);
  typedef enum logic {IDLE, MAC} state_e;
  state_e state_q, state_d;
  logic [2:0]  cnt_q;
  logic [31:0] coef_q [5];
  logic [31:0] xn_q, x1_q, x2_q, y1_q, y2_q, acc_q, y_q;
  logic        y_valid_q;
  logic [31:0] acc_step;
  logic        accept, last;
  assign accept = (state_q == IDLE) && x_valid_i && !clear_i;
  assign last   = (state_q == MAC) && (cnt_q == 3'd4);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (clear_i) state_d = IDLE;
    else if (accept) state_d = MAC;
    else if (last) state_d = IDLE;
  end
  always_comb begin
    x_ready_o = (state_q == IDLE);
    busy_o    = (state_q == MAC);
    y_valid_o = y_valid_q;
    y_o       = y_q;
    mult_a_o  = !busy_o ? '0 : cnt_q == 3'd0 ? xn_q : cnt_q == 3'd1 ? x1_q :
                cnt_q == 3'd2 ? x2_q : cnt_q == 3'd3 ? y1_q : y2_q;
    mult_b_o  = !busy_o ? '0 : cnt_q == 3'd0 ? coef_q[0] : cnt_q == 3'd1 ? coef_q[1] :
                cnt_q == 3'd2 ? coef_q[2] : cnt_q == 3'd3 ? coef_q[3] : coef_q[4];
  end
  // Feed-forward terms (cnt 0..2) add, feedback terms (cnt 3..4) subtract.
`ifdef IIR_SAT_EN
  logic signed [32:0] sum;
  assign sum = (cnt_q < 3'd3) ? $signed({acc_q[31], acc_q}) + $signed({mult_p_i[31], mult_p_i})
                              : $signed({acc_q[31], acc_q}) - $signed({mult_p_i[31], mult_p_i});
  assign acc_step = (sum[32] != sum[31]) ? (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum[31:0];
`else
  assign acc_step = (cnt_q < 3'd3) ? acc_q + mult_p_i : acc_q - mult_p_i;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 5; i++) coef_q[i] <= '0;
      cnt_q     <= '0;
      xn_q      <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      if (state_q == IDLE && coef_we_i && coef_addr_i < 3'd5) coef_q[coef_addr_i] <= coef_data_i;
      if (clear_i) begin
        x1_q  <= '0;
        x2_q  <= '0;
        y1_q  <= '0;
        y2_q  <= '0;
        acc_q <= '0;
      end else if (accept) begin
        xn_q  <= x_i;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (busy_o) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 3'd1;
        if (last) begin
          y_q       <= acc_step;
          y_valid_q <= 1'b1;
          x2_q      <= x1_q;
          x1_q      <= xn_q;
          y2_q      <= y1_q;
          y1_q      <= acc_step;
        end
      end
    end
  end
endmodule

// File: doc/iir_mac_sequencer.md
# iir_mac_sequencer

Sequencer for one Q16.16 direct-form-I biquad stage built around a single shared combinational Q16.16 multiplier. It accepts one input sample through a valid/ready handshake and time-multiplexes the five coefficient products onto the multiplier. It accumulates the products, updates the x/y history registers and emits one output sample. It sits between the sample source and the next filter stage, with the multiplier instantiated beside it.

## Interface
- No parameters. Data width is fixed at 32 bits, Q16.16 two's complement.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- clear_i  in  1  synchronous pulse; zeroes history and aborts any computation in progress.
- coef_we_i  in  1  coefficient write strobe.
- coef_addr_i  in  3  coefficient address: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 are ignored.
- coef_data_i  in  32  coefficient value, Q16.16.
- x_valid_i  in  1  input sample valid.
- x_i  in  32  input sample, Q16.16.
- x_ready_o  out  1  high when a sample can be accepted.
- y_valid_o  out  1  one-cycle pulse marking y_o valid.
- y_o  out  32  output sample, Q16.16.
- busy_o  out  1  high while in MAC.
- mult_a_o  out  32  multiplier operand A (data term).
- mult_b_o  out  32  multiplier operand B (coefficient).
- mult_p_i  in  32  multiplier result: bits [47:16] of the signed 64-bit product, same cycle.

## Operation
- Computes y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2].
- States:
  - IDLE: x_ready_o=1.
  - MAC: term counter cnt runs 0..4.
- IDLE→MAC when x_valid_i=1 and clear_i=0 at an edge. That edge does three things:
  - captures x_i into xn;
  - clears acc to 0;
  - sets cnt=0.
- In MAC, operands are driven combinationally from cnt:
  - cnt 0: (xn, b0)
  - cnt 1: (x1, b1)
  - cnt 2: (x2, b2)
  - cnt 3: (y1, a1)
  - cnt 4: (y2, a2)
- In IDLE, mult_a_o and mult_b_o are 0.
- Each MAC edge updates acc: acc + mult_p_i for cnt 0–2, acc − mult_p_i for cnt 3–4. Arithmetic is 32-bit; overflow handling is set by the Configuration section.
- The edge at cnt=4 does all of the following:
  - registers the final sum into y_o;
  - sets y_valid_o for one cycle;
  - shifts history: x2←x1, x1←xn, y2←y1, y1←new y;
  - returns the state to IDLE.
- Coefficient writes:
  - When state=IDLE, a write takes effect at the edge.
  - When busy_o=1, a write is dropped with no effect.
  - Addresses 5–7 are ignored.
- clear_i:
  - Zeroes x1, x2, y1, y2 and acc.
  - Forces the state to IDLE.
  - y_valid_o stays 0 for the aborted sample.
  - Coefficients and y_o are kept.
- clear_i and x_valid_i in the same cycle: clear wins and the sample is not accepted.
- clear_i and coef_we_i in the same IDLE cycle: both take effect.

## Timing
- Reset values:
  - state IDLE, x_ready_o=1, y_valid_o=0, busy_o=0;
  - y_o, mult_a_o, mult_b_o = 0;
  - all coefficients, history and acc = 0.
- Latency: sample accepted at edge E0 → y_valid_o high in the cycle after edge E5.
- Throughput: one sample per 6 cycles. The next sample can be accepted at E6, i.e. in the cycle where y_valid_o is high.
- y_o holds its value until the next completed sample.
- Reset asserted mid-MAC returns everything to reset values immediately, with no output pulse.

## Configuration
- IIR_SAT_EN defined:
  - every accumulate step uses a 33-bit signed result clamped to 0x7FFFFFFF / 0x80000000;
  - clamping happens per step, so y_o is always the clamped value.
- IIR_SAT_EN undefined: accumulation wraps modulo 2^32.

## Test plan
- Gain:
  - write b0=0x00008000 (0.5), all other coefficients 0;
  - send x=0x00050000 (5.0);
  - expect y_valid_o pulse after exactly 5 edges, y_o=0x00028000 (2.5).
- Recursion:
  - write b0=0x00010000 (1.0) and a1=0xFFFF8000 (−0.5);
  - send x = 0x00010000, 0, 0;
  - expect y = 0x00010000, 0x00008000, 0x00004000.
- Overflow:
  - write b0=b1=0x00010000;
  - send x=0x7FFF0000 twice;
  - second output: 0x7FFFFFFF with IIR_SAT_EN, 0xFFFE0000 without.
- Clear mid-operation:
  - assert clear_i at cnt=2;
  - expect no y_valid_o, x_ready_o=1 next cycle, and history zeroed;
  - re-running the gain test then gives 0x00028000.
- Back-to-back:
  - hold x_valid_i=1 continuously;
  - expect acceptance every 6 cycles and y_valid_o pulses 6 cycles apart;
  - a coef_we_i during MAC leaves the results unchanged.
